// File: rtl/obi_uart_rx_core.sv
// ============================================================================
// Module   : obi_uart_rx_core
// Brief    : 16x-oversampled UART receiver: start/data/parity/stop framing,
//            parity, framing and break status, one-cycle valid strobe.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module obi_uart_rx_core (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       baud_tick_i,
  input  logic [1:0] word_len_i,
  input  logic       par_en_i,
  input  logic       even_par_i,
  input  logic       force_par_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       par_err_o,
  output logic       frame_err_o,
  output logic       break_o,
  output logic       busy_o
);

  localparam int unsigned NR_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    RXIDLE          = 3'd0,
    RXSTART         = 3'd1,
    RXDATA          = 3'd2,
    RXPAR           = 3'd3,
    RXSTOP          = 3'd4,
    RXRESYNCHRONIZE = 3'd5
  } state_type_rx_e;

  state_type_rx_e state_q, state_d;

  logic [NR_SYNC_STAGES-1:0] sync_q;
  logic                      rx_s;
  logic                      armed_q;
  logic [3:0]                os_cnt;
  logic [2:0]                bit_cnt;
  logic [7:0]                shift_q;
  logic                      par_bit_q;
  logic [1:0]                word_len_q;
  logic                      par_en_q;
  logic                      even_par_q;
  logic                      force_par_q;

  logic start_det;
  logic mid_tick;
  logic smp_tick;
  logic last_bit;
  logic exp_par;

  assign rx_s = sync_q[NR_SYNC_STAGES-1];

  // armed_q is only set after a full cycle in RXIDLE with the line high, so a
  // low line at the moment of returning to idle is never taken as a start.
  assign start_det = (state_q == RXIDLE) && armed_q && !rx_s;
  assign mid_tick  = baud_tick_i && (os_cnt == 4'd7);
  assign smp_tick  = baud_tick_i && (os_cnt == 4'd15);
  assign last_bit  = (bit_cnt == ({1'b0, word_len_q} + 3'd4));
  // Unused upper bits of shift_q stay 0, so a full-width XOR is exact.
  assign exp_par   = force_par_q ? ~even_par_q :
                     (even_par_q ? ^shift_q : ~(^shift_q));
  assign busy_o    = (state_q != RXIDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RXIDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RXIDLE:          if (start_det) state_d = RXSTART;
      RXSTART:         if (mid_tick) state_d = rx_s ? RXIDLE : RXDATA;
      RXDATA:          if (smp_tick && last_bit) state_d = par_en_q ? RXPAR : RXSTOP;
      RXPAR:           if (smp_tick) state_d = RXSTOP;
      RXSTOP:          if (smp_tick) state_d = rx_s ? RXIDLE : RXRESYNCHRONIZE;
      RXRESYNCHRONIZE: if (rx_s) state_d = RXIDLE;
      default:         state_d = RXIDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '1;
      armed_q     <= 1'b0;
      os_cnt      <= 4'd0;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'd0;
      par_bit_q   <= 1'b0;
      word_len_q  <= 2'd0;
      par_en_q    <= 1'b0;
      even_par_q  <= 1'b0;
      force_par_q <= 1'b0;
      data_o      <= 8'd0;
      valid_o     <= 1'b0;
      par_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      break_o     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NR_SYNC_STAGES-2:0], rx_i};
      armed_q <= (state_q == RXIDLE) && rx_s;
      valid_o <= 1'b0;

      if (start_det || ((state_q == RXSTART) && mid_tick)) begin
        os_cnt <= 4'd0;
      end else if (baud_tick_i) begin
        os_cnt <= os_cnt + 4'd1;
      end

      if (start_det) begin
        word_len_q  <= word_len_i;
        par_en_q    <= par_en_i;
        even_par_q  <= even_par_i;
        force_par_q <= force_par_i;
        shift_q     <= 8'd0;
        bit_cnt     <= 3'd0;
        par_bit_q   <= 1'b0;
      end

      if ((state_q == RXDATA) && smp_tick) begin
        shift_q[bit_cnt] <= rx_s;
        bit_cnt          <= bit_cnt + 3'd1;
      end

      if ((state_q == RXPAR) && smp_tick) begin
        par_bit_q <= rx_s;
      end

      if ((state_q == RXSTOP) && smp_tick) begin
        data_o      <= shift_q;
        valid_o     <= 1'b1;
        par_err_o   <= par_en_q && (par_bit_q != exp_par);
        frame_err_o <= !rx_s;
        break_o     <= (shift_q == 8'd0) && !(par_en_q && par_bit_q) && !rx_s;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_uart_rx_core.sv
// ============================================================================
// Module   : tb_obi_uart_rx_core
// Brief    : Directed and random frames against a frame-level reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obi_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       baud_tick;
  logic [1:0] word_len = 2'd3;
  logic       par_en = 1'b0;
  logic       even_par = 1'b0;
  logic       force_par = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       par_err;
  logic       frame_err;
  logic       brk;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [1:0] tick_cnt = 2'd0;
  int         tick_total = 0;
  int         start_tick = 0;

  int         vcount = 0;
  int         dbl = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] cap_data = 8'd0;
  logic       cap_pe = 1'b0, cap_fe = 1'b0, cap_brk = 1'b0;
  int         cap_tick = 0;

  obi_uart_rx_core dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .baud_tick_i (baud_tick),
    .word_len_i  (word_len),
    .par_en_i    (par_en),
    .even_par_i  (even_par),
    .force_par_i (force_par),
    .data_o      (data),
    .valid_o     (valid),
    .par_err_o   (par_err),
    .frame_err_o (frame_err),
    .break_o     (brk),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Baud strobe every 4 clocks.
  assign baud_tick = (tick_cnt == 2'd3);
  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    if (baud_tick) tick_total <= tick_total + 1;
  end

  always @(negedge clk) begin
    if (valid) begin
      vcount   = vcount + 1;
      cap_data = data;
      cap_pe   = par_err;
      cap_fe   = frame_err;
      cap_brk  = brk;
      cap_tick = tick_total;
    end
    if (valid && prev_valid) dbl = dbl + 1;
    prev_valid = valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Consume n baud ticks; returns 1ns after the clock edge that used the last one.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!baud_tick) @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: what a receiver must report for the frame as sent on the wire.
  task automatic model(input logic [1:0] wl, input logic pe, input logic ep, input logic fp,
                       input logic [7:0] d, input logic pb, input logic sb,
                       output logic [7:0] ed, output logic epe, output logic efe,
                       output logic ebrk);
    int   n;
    int   mask;
    logic p;
    n    = 5 + int'(wl);
    mask = (1 << n) - 1;
    ed   = d & mask[7:0];
    if (fp)      p = !ep;
    else if (ep) p = ($countones(ed) % 2) == 1;
    else         p = ($countones(ed) % 2) == 0;
    epe  = pe && (pb != p);
    efe  = !sb;
    ebrk = (ed == 8'd0) && (!pe || !pb) && !sb;
  endtask

  task automatic send_frame(input logic [1:0] wl, input logic pe, input logic ep, input logic fp,
                            input logic [7:0] d, input logic pb, input logic sb,
                            input bit scramble);
    word_len   = wl;
    par_en     = pe;
    even_par   = ep;
    force_par  = fp;
    start_tick = tick_total;
    rx = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      word_len  = 2'($urandom);
      par_en    = 1'($urandom);
      even_par  = 1'($urandom);
      force_par = 1'($urandom);
    end
    for (int i = 0; i < 5 + int'(wl); i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (pe) begin
      rx = pb;
      wait_ticks(16);
    end
    rx = sb;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(32);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] wl, input logic pe,
                           input logic ep, input logic fp, input logic [7:0] d,
                           input logic pb, input logic sb, input bit scramble);
    int         v0;
    logic [7:0] ed;
    logic       epe, efe, ebrk;
    v0 = vcount;
    model(wl, pe, ep, fp, d, pb, sb, ed, epe, efe, ebrk);
    send_frame(wl, pe, ep, fp, d, pb, sb, scramble);
    check({tag, "_count"}, vcount, v0 + 1);
    check({tag, "_data"}, cap_data, ed);
    check({tag, "_par_err"}, cap_pe, epe);
    check({tag, "_frame_err"}, cap_fe, efe);
    check({tag, "_break"}, cap_brk, ebrk);
  endtask

  initial begin
    int         v0;
    int         lat;
    logic [7:0] c3;
    logic [1:0] wl;
    logic       pe, ep, fp, pb, sb;
    logic [7:0] d;

    repeat (5) @(posedge clk);
    #1;
    check("rst_data", data, 8'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_break", brk, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5 plus start-to-valid latency in ticks
    run_frame("a5_8n1", 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    lat = cap_tick - start_tick;
    check("a5_latency_in_range", (lat >= 150 && lat <= 162), 1'b1);

    // 7E1 0x35: correct parity, then flipped parity
    run_frame("x35_7e1_good", 2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 1'b0);
    run_frame("x35_7e1_bad", 2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 1'b0);

    // 5-bit, forced parity with even_par=1
    run_frame("x1f_5f1", 2'd0, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b1, 1'b0);

    // Break: line low for two 8N1 frame times
    word_len = 2'd3;
    par_en   = 1'b0;
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(320);
    check("brk_count", vcount, v0 + 1);
    check("brk_data", cap_data, 8'd0);
    check("brk_frame_err", cap_fe, 1'b1);
    check("brk_break", cap_brk, 1'b1);
    check("brk_busy_resync", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(32);
    check("brk_busy_released", busy, 1'b0);
    check("brk_no_second", vcount, v0 + 1);

    // Glitch of 3 ticks, then a clean 0x55
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(32);
    check("glitch_no_valid", vcount, v0);
    check("glitch_idle", busy, 1'b0);
    run_frame("x55_after_glitch", 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);

    // Reset during data bit 3 of 0xC3
    c3 = 8'hC3;
    v0 = vcount;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = c3[i];
      wait_ticks(16);
    end
    rx = c3[3];
    wait_ticks(8);
    rst = 1'b1;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", valid, 1'b0);
    check("mrst_data", data, 8'd0);
    check("mrst_flags", {par_err, frame_err, brk}, 3'b000);
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(32);
    check("mrst_no_valid", vcount, v0);
    run_frame("xc3_after_rst", 2'd3, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);

    // Random frames; LCR inputs are scrambled mid-frame
    for (int k = 0; k < 12; k++) begin
      wl = 2'($urandom_range(0, 3));
      pe = 1'($urandom_range(0, 1));
      ep = 1'($urandom_range(0, 1));
      fp = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      run_frame("rnd", wl, pe, ep, fp, d, pb, sb, 1'b1);
    end

    check("single_cycle_valid", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obi_uart_rx_core.md
OBI_UART_RX_CORE -- requirements
Module: obi_uart_rx_core

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset, named as follows.
REQ-002 clk_i  input  1  block clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 rx_i  input  1  raw serial line; asynchronous to clk_i; idle level 1.
REQ-005 baud_tick_i  input  1  one-cycle strobe at 16x the bit rate, produced by the divisor (DLL/DLM) generator.
REQ-006 word_len_i  input  2  LCR word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 par_en_i, even_par_i, force_par_i  input  1 each  LCR parity controls.
REQ-008 data_o  output  8  received character, LSB-aligned, upper unused bits 0.
REQ-009 valid_o  output  1  one-cycle pulse; data_o and the error flags are valid in that cycle.
REQ-010 par_err_o, frame_err_o, break_o  output  1 each  per-character status, qualified by valid_o.
REQ-011 busy_o  output  1  high whenever the state is not RXIDLE.

Function
REQ-012 rx_i SHALL pass through a synchronizer of 2 flops (NrSyncStages) reset to 1; all logic uses the synchronized value (rx_s) only.
REQ-013 The FSM states SHALL be RXIDLE, RXSTART, RXDATA, RXPAR, RXSTOP, RXRESYNCHRONIZE (state_type_rx_e).
REQ-014 A 4-bit oversample counter (os_cnt) SHALL increment only on baud_tick_i and wrap 15->0.
REQ-015 RXIDLE: when rx_s goes from 1 to 0 (edge on clk_i, independent of baud_tick_i), the block SHALL clear os_cnt, latch word_len/par_en/even_par/force_par, and enter RXSTART.
REQ-016 Changes to the LCR inputs after the latch SHALL NOT affect the frame in progress.
REQ-017 RXSTART: on the baud_tick_i where os_cnt==7 (mid-bit), the block SHALL clear os_cnt and enter RXDATA if rx_s==0; if rx_s==1 it SHALL return to RXIDLE (glitch) with no valid_o.
REQ-018 RXDATA/RXPAR/RXSTOP: each bit SHALL be sampled on the baud_tick_i where os_cnt==15, i.e. 16 ticks after the previous sample.
REQ-019 RXDATA: data SHALL be shifted in LSB-first; after 5+word_len samples the FSM goes to RXPAR if par_en, else to RXSTOP.
REQ-020 Expected parity SHALL be: if force_par, ~even_par; else if even_par, XOR of data bits; else ~XOR of data bits.
REQ-021 par_err SHALL be set when the sampled parity bit differs from the expected parity; it is 0 when parity is disabled.
REQ-022 RXSTOP: only one stop bit SHALL be checked, regardless of the LCR stop_bits setting; frame_err = (sampled stop == 0).
REQ-023 break SHALL be set when all data bits, the parity bit (if enabled) and the stop bit are 0.
REQ-024 valid_o SHALL pulse exactly one cycle, in the cycle after the stop sample; data_o and the flags hold until the next valid_o.
REQ-025 After the stop sample, the FSM SHALL go to RXIDLE if stop==1, else to RXRESYNCHRONIZE.
REQ-026 RXRESYNCHRONIZE SHALL wait until rx_s==1, then enter RXIDLE; no new start is detected before then.
REQ-027 A falling edge of rx_s in the same cycle as the return to RXIDLE SHALL NOT be detected; the detector needs rx_s==1 for at least one cycle while in RXIDLE.
REQ-028 The block SHALL have no backpressure; the consumer (RX FIFO/register stage) must accept every valid_o pulse and handles overrun.

Reset
REQ-029 While rst_i is high, the block SHALL hold: state=RXIDLE; os_cnt=0; bit counter=0; shift register=0; synchronizer flops=1; data_o=0; valid_o=0; all error flags=0; busy_o=0.
REQ-030 If rst_i asserts mid-frame, the partial character SHALL be discarded with no valid_o; after release, reception resumes only on a new falling edge.

Verification
REQ-031 8N1 line: send 0xA5 with ticks every 4 clocks -> exactly one valid_o, data_o=0xA5, all flags 0, ~160 ticks after the start edge.
REQ-032 7E1 line: send 0x35 with a correct parity bit (0), then the same character with the parity bit flipped -> data_o=0x35 both times; par_err_o=0 for the first character and 1 for the second.
REQ-033 5-bit, force parity with even_par=1: send data 0x1F with parity bit 0 -> data_o=0x1F, par_err_o=0.
REQ-034 Break: hold the line at 0 for 2 frame times, then release -> one valid_o with data_o=0x00, frame_err_o=1, break_o=1; the FSM stays in RXRESYNCHRONIZE until the line goes high and no second valid_o occurs.
REQ-035 Glitch: a 0-pulse of 3 ticks on an idle line -> return to RXIDLE, no valid_o; a following 0x55 is received correctly.
REQ-036 Reset mid-frame: assert rst_i during data bit 3 -> all outputs 0 immediately; after release, the next full frame (0xC3) is received correctly.
